rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Write-side front end of the register file; the single producer of the RF write port (WB_Dst, WB_Result, RFWr).
- Merges two result sources into one RF write per cycle:
  - the in-order pipeline result (MEM/WB boundary);
  - an out-of-band long-latency source (divider, uncached load return), queued in a 4-entry FIFO.
- Reports to ID which architectural registers still have a write in flight, so ID stalls instead of reading stale data.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..8.
- AW, 5, register-index width.
- DW, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high (`RstEnable`).
- pipe_wr  in  1  pipeline result valid this cycle.
- pipe_dst  in  AW  pipeline destination register.
- pipe_data  in  DW  pipeline result.
- lsrc_valid  in  1  long-latency result offered.
- lsrc_ready  out  1  queue accepts offer this cycle.
- lsrc_dst  in  AW  long-latency destination.
- lsrc_data  in  DW  long-latency result.
- WB_Dst  out  AW  RF write index.
- WB_Result  out  DW  RF write data.
- RFWr  out  1  RF write enable.
- ID_rs  in  AW  ID source register A.
- ID_rt  in  AW  ID source register B.
- ID_PendRs  out  1  write to ID_rs still in flight.
- ID_PendRt  out  1  write to ID_rt still in flight.

Behaviour:
- Reset, synchronous:
  - RFWr=0, WB_Dst=0, WB_Result=0.
  - All queue entries invalid; head=tail=0; count=0.
  - lsrc_ready=1 from the first cycle after reset.
  - A reset mid-operation discards all queued results.
- Output stage:
  - WB_Dst, WB_Result and RFWr are registered, so there is exactly 1 cycle from the winning source to the RF port.
  - The RF commits on the edge after RFWr is high.
- Arbitration, evaluated each cycle:
  1. If pipe_wr=1 and pipe_dst!=0, the pipeline wins: output <= {pipe_dst, pipe_data}, RFWr<=1.
  2. Else, if the queue head is valid and live: output <= head entry, RFWr<=1, pop.
  3. Else, if the queue head is a dead entry: pop, RFWr<=0.
  4. Else: RFWr<=0.
  - Only one pop per cycle. A pipeline write never stalls.
- $0 handling:
  - A pipeline write with pipe_dst=0 is treated as no write, and the queue may drain that cycle.
  - An lsrc handshake with lsrc_dst=0 is consumed (the ready/valid exchange completes) but nothing is enqueued.
- Enqueue:
  - A handshake occurs when lsrc_valid && lsrc_ready.
  - The entry is written at tail with live=1; tail increments mod DEPTH.
  - lsrc_ready = (count != DEPTH). It does not depend on a same-cycle pop.
  - Push and pop in the same cycle leave count unchanged.
- Ordering and WAW:
  - When a pipeline write to register X is accepted, every valid queue entry with dst==X is marked dead. The younger in-order result wins.
  - An entry enqueued in the same cycle with dst==X is also marked dead.
  - Dead entries occupy a slot until popped and never assert RFWr.
- Pending flags, combinational:
  - ID_PendRs = (ID_rs!=0) && (any valid, live queue entry with dst==ID_rs, OR (RFWr && WB_Dst==ID_rs)).
  - ID_PendRt is computed the same way using ID_rt.
  - The output register is included because the RF has not committed the value yet.
- Counter and pointers:
  - count is a 0..DEPTH counter.
  - head and tail are log2(DEPTH)-bit pointers with natural wrap.
  - Full is count==DEPTH; empty is count==0.
- Invariant: pushing when full is impossible (ready=0), and popping when empty is impossible. Add an assertion on each.

Decomposition:
- Shared package cpu_wb_pkg:
  - typedef wb_req_t {dst[AW], data[DW]};
  - typedef for a queue entry: wb_req_t + valid + live;
  - constant WB_QDEPTH=4.
- One sub-module, wb_queue:
  - contains the FIFO storage, pointers, count and the kill-by-dst compare;
  - exposes a head entry, pop, push and kill_dst;
  - exposes a match vector for the pending logic.
- Arbitration, the output register and the pending OR-reduction stay in rf_wb_arbiter.

Test Plan:
1. Reset, then idle → RFWr=0, lsrc_ready=1, ID_PendRs=ID_PendRt=0.
2. lsrc pushes {r5, 0xDEAD0005} with pipe idle → next cycle RFWr=1, WB_Dst=5, WB_Result=0xDEAD0005. ID_rs=5 shows PendRs=1 during enqueue and output cycles, then 0 after.
3. Push 4 entries r1..r4 while pipe_wr=1 to r9 for 6 cycles:
   - lsrc_ready=0 after the 4th push;
   - pipe results reach the RF each cycle;
   - afterwards r1..r4 drain in order, one per cycle.
4. Queue holds r7=0x11; pipe_wr r7=0x22 in the same cycle → RF gets r7=0x22. The dead entry pops with RFWr=0, and PendRs for r7 clears after the output cycle.
5. pipe_wr with dst 0 while the queue holds r3 → r3 drains that cycle. An lsrc push with dst 0 completes the handshake but leaves count unchanged.
6. Queue of 3 entries, assert rst for 1 cycle → count=0, RFWr=0, lsrc_ready=1 next cycle. No stale writes appear afterward.

Source files
------------

// File: rtl/cpu_wb_pkg.sv
// Purpose: shared types and sizes for the register-file write-back front end.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package cpu_wb_pkg;

  localparam int WB_AW     = 5;
  localparam int WB_DW     = 32;
  localparam int WB_QDEPTH = 4;

  // One register-file write request.
  typedef struct packed {
    logic [WB_AW-1:0] dst;
    logic [WB_DW-1:0] data;
  } wb_req_t;

  // Queue slot: a request plus occupancy and liveness.
  // A dead slot still occupies the queue but will never reach the RF.
  typedef struct packed {
    logic    valid;
    logic    live;
    wb_req_t req;
  } wb_qent_t;

  // True when a slot holds a write that will still land on register r.
  function automatic logic wb_live_hit(input wb_qent_t e, input logic [WB_AW-1:0] r);
    return e.valid && e.live && (e.req.dst == r);
  endfunction

endpackage

// File: rtl/wb_queue.sv
// Purpose: small in-order queue of long-latency results with kill-by-destination.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: full is reported to the caller, which must not push while full.
module wb_queue
  import cpu_wb_pkg::*;
#(
  parameter int DEPTH = WB_QDEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  wb_req_t              push_req,
  input  logic                 pop,
  input  logic                 kill,
  input  logic [WB_AW-1:0]     kill_dst,
  input  logic [WB_AW-1:0]     probe_a,
  input  logic [WB_AW-1:0]     probe_b,
  output wb_qent_t             head,
  output logic                 full,
  output logic [DEPTH-1:0]     match_a,
  output logic [DEPTH-1:0]     match_b
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_qent_t        ent [DEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [CW-1:0]   count;
  logic            empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = ent[head_ptr];

  // Storage, pointers and occupancy; a kill marks every matching slot dead,
  // including a slot being filled this very cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && ent[i].valid && (ent[i].req.dst == kill_dst)) begin
          ent[i].live <= 1'b0;
        end
      end
      if (pop) begin
        ent[head_ptr].valid <= 1'b0;
        head_ptr            <= head_ptr + 1'b1;
      end
      if (push) begin
        ent[tail_ptr] <= '{valid: 1'b1,
                           live:  !(kill && (push_req.dst == kill_dst)),
                           req:   push_req};
        tail_ptr      <= tail_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Per-slot hits for the two ID probe registers; only live writes count.
  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_a[i] = wb_live_hit(ent[i], probe_a);
      match_b[i] = wb_live_hit(ent[i], probe_b);
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/rf_wb_arbiter.sv
// Purpose: single producer of the RF write port, merging pipeline and long-latency results.
// Latency: 1 cycle from the winning source to WB_Dst/WB_Result/RFWr.
// Backpressure: pipeline never stalls; lsrc is held off only while the queue is full.
module rf_wb_arbiter
  import cpu_wb_pkg::*;
#(
  parameter int DEPTH = WB_QDEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_wr,
  input  logic [AW-1:0] pipe_dst,
  input  logic [DW-1:0] pipe_data,
  input  logic          lsrc_valid,
  output logic          lsrc_ready,
  input  logic [AW-1:0] lsrc_dst,
  input  logic [DW-1:0] lsrc_data,
  output logic [AW-1:0] WB_Dst,
  output logic [DW-1:0] WB_Result,
  output logic          RFWr,
  input  logic [AW-1:0] ID_rs,
  input  logic [AW-1:0] ID_rt,
  output logic          ID_PendRs,
  output logic          ID_PendRt
);

  wb_qent_t         q_head;
  logic             q_full;
  logic [DEPTH-1:0] match_rs;
  logic [DEPTH-1:0] match_rt;
  logic             pipe_win;
  logic             lsrc_push;
  logic             q_pop;
  wb_req_t          lsrc_req;

  // Writes to $0 are architecturally void: the pipeline yields the port and a
  // long-latency $0 result completes its handshake without taking a slot.
  assign pipe_win   = pipe_wr && (pipe_dst != '0);
  assign lsrc_ready = !q_full;
  assign lsrc_push  = lsrc_valid && lsrc_ready && (lsrc_dst != '0);
  assign q_pop      = !pipe_win && q_head.valid;
  assign lsrc_req   = '{dst: lsrc_dst, data: lsrc_data};

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (lsrc_push),
    .push_req (lsrc_req),
    .pop      (q_pop),
    .kill     (pipe_win),
    .kill_dst (pipe_dst),
    .probe_a  (ID_rs),
    .probe_b  (ID_rt),
    .head     (q_head),
    .full     (q_full),
    .match_a  (match_rs),
    .match_b  (match_rt)
  );

  // Output register: pipeline first, then a live queue head; a dead head is
  // popped silently. Index/data hold their last value while RFWr is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      RFWr      <= 1'b0;
      WB_Dst    <= '0;
      WB_Result <= '0;
    end else if (pipe_win) begin
      RFWr      <= 1'b1;
      WB_Dst    <= pipe_dst;
      WB_Result <= pipe_data;
    end else if (q_pop && q_head.live) begin
      RFWr      <= 1'b1;
      WB_Dst    <= q_head.req.dst;
      WB_Result <= q_head.req.data;
    end else begin
      RFWr      <= 1'b0;
    end
  end

  // A register is pending while a live queued write targets it or while the
  // output register holds a write the RF has not committed yet.
  always_comb begin
    ID_PendRs = (ID_rs != '0) && ((|match_rs) || (RFWr && (WB_Dst == ID_rs)));
    ID_PendRt = (ID_rt != '0) && ((|match_rt) || (RFWr && (WB_Dst == ID_rt)));
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Purpose: self-checking bench for rf_wb_arbiter, directed scenarios plus random traffic.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: drives lsrc_valid freely; the model honours lsrc_ready.
module tb_rf_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_wr = 1'b0;
  logic [4:0]  pipe_dst = '0;
  logic [31:0] pipe_data = '0;
  logic        lsrc_valid = 1'b0;
  logic        lsrc_ready;
  logic [4:0]  lsrc_dst = '0;
  logic [31:0] lsrc_data = '0;
  logic [4:0]  WB_Dst;
  logic [31:0] WB_Result;
  logic        RFWr;
  logic [4:0]  ID_rs = '0;
  logic [4:0]  ID_rt = '0;
  logic        ID_PendRs;
  logic        ID_PendRt;

  int n_cmp = 0;
  int n_bad = 0;

  rf_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_wr    (pipe_wr),
    .pipe_dst   (pipe_dst),
    .pipe_data  (pipe_data),
    .lsrc_valid (lsrc_valid),
    .lsrc_ready (lsrc_ready),
    .lsrc_dst   (lsrc_dst),
    .lsrc_data  (lsrc_data),
    .WB_Dst     (WB_Dst),
    .WB_Result  (WB_Result),
    .RFWr       (RFWr),
    .ID_rs      (ID_rs),
    .ID_rt      (ID_rt),
    .ID_PendRs  (ID_PendRs),
    .ID_PendRt  (ID_PendRt)
  );

  always #5 clk = ~clk;

  // Reference model: a list of outstanding long-latency writes plus the
  // pending RF write.
  typedef struct {
    logic [4:0]  dst;
    logic [31:0] data;
    bit          live;
  } ment_t;

  ment_t       mq[$];
  bit          e_rfwr = 0;
  logic [4:0]  e_dst  = '0;
  logic [31:0] e_data = '0;

  function automatic bit m_pend(input logic [4:0] r);
    if (r == 0) return 0;
    if (e_rfwr && e_dst == r) return 1;
    foreach (mq[i]) if (mq[i].live && mq[i].dst == r) return 1;
    return 0;
  endfunction

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic step();
    bit    rdy;
    bit    pw;
    ment_t h;
    rdy = (mq.size() != DEPTH);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      e_rfwr = 0; e_dst = '0; e_data = '0;
    end else begin
      pw = pipe_wr && (pipe_dst != 0);
      if (pw) begin
        e_rfwr = 1; e_dst = pipe_dst; e_data = pipe_data;
        foreach (mq[i]) if (mq[i].dst == pipe_dst) mq[i].live = 0;
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        e_rfwr = h.live;
        if (h.live) begin e_dst = h.dst; e_data = h.data; end
      end else begin
        e_rfwr = 0;
      end
      if (lsrc_valid && rdy && lsrc_dst != 0)
        mq.push_back('{dst: lsrc_dst, data: lsrc_data, live: !(pw && lsrc_dst == pipe_dst)});
    end
    #1;
  endtask

  task automatic idle();
    pipe_wr = 0; pipe_dst = '0; pipe_data = '0;
    lsrc_valid = 0; lsrc_dst = '0; lsrc_data = '0;
  endtask

  task automatic test_reset();
    idle(); ID_rs = 5'd3; ID_rt = 5'd4;
    rst = 1; step(); step();
    rst = 0; step();
    n_cmp++; if (RFWr !== 1'b0) begin n_bad++; $display("FAIL reset_rfwr got %0b want 0", RFWr); end
    n_cmp++; if (WB_Dst !== 5'd0) begin n_bad++; $display("FAIL reset_dst got %0d want 0", WB_Dst); end
    n_cmp++; if (WB_Result !== 32'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", WB_Result); end
    n_cmp++; if (lsrc_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0b want 1", lsrc_ready); end
    n_cmp++; if (ID_PendRs !== 1'b0 || ID_PendRt !== 1'b0) begin n_bad++; $display("FAIL reset_pend got %0b%0b want 00", ID_PendRs, ID_PendRt); end
  endtask

  task automatic test_single_push();
    idle(); ID_rs = 5'd5; ID_rt = 5'd0;
    lsrc_valid = 1; lsrc_dst = 5'd5; lsrc_data = 32'hDEAD0005;
    step();
    idle();
    n_cmp++; if (RFWr !== 1'b0 || ID_PendRs !== 1'b1) begin n_bad++; $display("FAIL single_enq got rfwr=%0b pend=%0b want rfwr=0 pend=1", RFWr, ID_PendRs); end
    step();
    n_cmp++; if (RFWr !== 1'b1 || WB_Dst !== 5'd5 || WB_Result !== 32'hDEAD0005) begin n_bad++; $display("FAIL single_out got %0b/%0d/%h want 1/5/dead0005", RFWr, WB_Dst, WB_Result); end
    n_cmp++; if (ID_PendRs !== 1'b1) begin n_bad++; $display("FAIL single_pend_out got %0b want 1", ID_PendRs); end
    step();
    n_cmp++; if (RFWr !== 1'b0 || ID_PendRs !== 1'b0) begin n_bad++; $display("FAIL single_after got rfwr=%0b pend=%0b want 0/0", RFWr, ID_PendRs); end
  endtask

  task automatic test_fill_with_pipe();
    idle(); ID_rs = 5'd0; ID_rt = 5'd0;
    for (int c = 0; c < 6; c++) begin
      pipe_wr = 1; pipe_dst = 5'd9; pipe_data = 32'h900 + c;
      lsrc_valid = (c < 4); lsrc_dst = 5'(c + 1); lsrc_data = 32'h100 + c + 1;
      step();
      n_cmp++; if (RFWr !== 1'b1 || WB_Dst !== 5'd9 || WB_Result !== 32'h900 + c) begin n_bad++; $display("FAIL fill_pipe c%0d got %0b/%0d/%h want 1/9/%h", c, RFWr, WB_Dst, WB_Result, 32'h900 + c); end
      if (c == 3) begin
        n_cmp++; if (lsrc_ready !== 1'b0) begin n_bad++; $display("FAIL fill_full_ready got %0b want 0", lsrc_ready); end
      end
    end
    idle();
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++; if (RFWr !== 1'b1 || WB_Dst !== 5'(k) || WB_Result !== 32'h100 + k) begin n_bad++; $display("FAIL fill_drain r%0d got %0b/%0d/%h want 1/%0d/%h", k, RFWr, WB_Dst, WB_Result, k, 32'h100 + k); end
    end
    step();
    n_cmp++; if (RFWr !== 1'b0) begin n_bad++; $display("FAIL fill_empty got %0b want 0", RFWr); end
  endtask

  task automatic test_waw_kill();
    idle(); ID_rs = 5'd7; ID_rt = 5'd8;
    lsrc_valid = 1; lsrc_dst = 5'd7; lsrc_data = 32'h11;
    step();
    idle(); pipe_wr = 1; pipe_dst = 5'd7; pipe_data = 32'h22;
    step();
    idle();
    n_cmp++; if (RFWr !== 1'b1 || WB_Dst !== 5'd7 || WB_Result !== 32'h22) begin n_bad++; $display("FAIL waw_out got %0b/%0d/%h want 1/7/22", RFWr, WB_Dst, WB_Result); end
    n_cmp++; if (ID_PendRs !== 1'b1) begin n_bad++; $display("FAIL waw_pend_out got %0b want 1", ID_PendRs); end
    step();
    n_cmp++; if (RFWr !== 1'b0 || ID_PendRs !== 1'b0) begin n_bad++; $display("FAIL waw_dead_pop got rfwr=%0b pend=%0b want 0/0", RFWr, ID_PendRs); end
    // Enqueue and pipeline write to the same register in one cycle.
    lsrc_valid = 1; lsrc_dst = 5'd8; lsrc_data = 32'h81;
    pipe_wr = 1; pipe_dst = 5'd8; pipe_data = 32'h82;
    step();
    idle();
    n_cmp++; if (RFWr !== 1'b1 || WB_Dst !== 5'd8 || WB_Result !== 32'h82) begin n_bad++; $display("FAIL waw_same_out got %0b/%0d/%h want 1/8/82", RFWr, WB_Dst, WB_Result); end
    step();
    n_cmp++; if (RFWr !== 1'b0 || ID_PendRt !== 1'b0) begin n_bad++; $display("FAIL waw_same_dead got rfwr=%0b pend=%0b want 0/0", RFWr, ID_PendRt); end
  endtask

  task automatic test_zero_dst();
    idle(); ID_rs = 5'd0; ID_rt = 5'd3;
    lsrc_valid = 1; lsrc_dst = 5'd3; lsrc_data = 32'h33;
    step();
    idle(); pipe_wr = 1; pipe_dst = 5'd0; pipe_data = 32'h99;
    step();
    n_cmp++; if (RFWr !== 1'b1 || WB_Dst !== 5'd3 || WB_Result !== 32'h33) begin n_bad++; $display("FAIL zero_pipe_drain got %0b/%0d/%h want 1/3/33", RFWr, WB_Dst, WB_Result); end
    n_cmp++; if (ID_PendRs !== 1'b0) begin n_bad++; $display("FAIL zero_pend_r0 got %0b want 0", ID_PendRs); end
    idle(); lsrc_valid = 1; lsrc_dst = 5'd0; lsrc_data = 32'h55;
    n_cmp++; if (lsrc_ready !== 1'b1) begin n_bad++; $display("FAIL zero_lsrc_ready got %0b want 1", lsrc_ready); end
    step();
    n_cmp++; if (RFWr !== 1'b0) begin n_bad++; $display("FAIL zero_lsrc_nowrite got %0b want 0", RFWr); end
    // Occupancy must be unaffected: exactly four further pushes fill the queue.
    for (int k = 0; k < 4; k++) begin
      pipe_wr = 1; pipe_dst = 5'd9; pipe_data = 32'h7;
      lsrc_valid = 1; lsrc_dst = 5'(11 + k); lsrc_data = 32'hB00 + k;
      step();
      n_cmp++; if (lsrc_ready !== (k != 3)) begin n_bad++; $display("FAIL zero_count k%0d ready got %0b want %0b", k, lsrc_ready, k != 3); end
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (RFWr !== 1'b1 || WB_Dst !== 5'(11 + k) || WB_Result !== 32'hB00 + k) begin n_bad++; $display("FAIL zero_drain k%0d got %0b/%0d/%h", k, RFWr, WB_Dst, WB_Result); end
    end
    step();
  endtask

  task automatic test_reset_midop();
    idle(); ID_rs = 5'd10; ID_rt = 5'd12;
    for (int k = 0; k < 3; k++) begin
      pipe_wr = 1; pipe_dst = 5'd9; pipe_data = 32'h1;
      lsrc_valid = 1; lsrc_dst = 5'(10 + k); lsrc_data = 32'hC00 + k;
      step();
    end
    idle(); rst = 1;
    step();
    rst = 0;
    n_cmp++; if (RFWr !== 1'b0 || WB_Dst !== 5'd0 || lsrc_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_state got rfwr=%0b dst=%0d rdy=%0b want 0/0/1", RFWr, WB_Dst, lsrc_ready); end
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++; if (RFWr !== 1'b0 || ID_PendRs !== 1'b0 || ID_PendRt !== 1'b0) begin n_bad++; $display("FAIL midrst_stale c%0d got rfwr=%0b pend=%0b%0b want 0/00", c, RFWr, ID_PendRs, ID_PendRt); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      pipe_wr    = ($urandom_range(0, 2) == 0);
      pipe_dst   = 5'($urandom_range(0, 7));
      pipe_data  = $urandom;
      lsrc_valid = ($urandom_range(0, 1) == 0);
      lsrc_dst   = 5'($urandom_range(0, 7));
      lsrc_data  = $urandom;
      ID_rs      = 5'($urandom_range(0, 7));
      ID_rt      = 5'($urandom_range(0, 7));
      step();
      n_cmp++; if (RFWr !== e_rfwr) begin n_bad++; $display("FAIL rand_rfwr c%0d got %0b want %0b", c, RFWr, e_rfwr); end
      if (e_rfwr) begin
        n_cmp++; if (WB_Dst !== e_dst || WB_Result !== e_data) begin n_bad++; $display("FAIL rand_out c%0d got %0d/%h want %0d/%h", c, WB_Dst, WB_Result, e_dst, e_data); end
      end
      n_cmp++; if (lsrc_ready !== (mq.size() != DEPTH)) begin n_bad++; $display("FAIL rand_ready c%0d got %0b want %0b", c, lsrc_ready, mq.size() != DEPTH); end
      n_cmp++; if (ID_PendRs !== m_pend(ID_rs)) begin n_bad++; $display("FAIL rand_pendrs c%0d rs=%0d got %0b want %0b", c, ID_rs, ID_PendRs, m_pend(ID_rs)); end
      n_cmp++; if (ID_PendRt !== m_pend(ID_rt)) begin n_bad++; $display("FAIL rand_pendrt c%0d rt=%0d got %0b want %0b", c, ID_rt, ID_PendRt, m_pend(ID_rt)); end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_with_pipe();
    test_waw_kill();
    test_zero_dst();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
